// File: rtl/playback_sequencer.sv
// playback_sequencer: sequences the stereo PCM playback path between the
// sample FIFO and the sigma-delta DACs. It pre-fills the FIFO, paces FIFO
// reads with the sample-rate tick, falls back to pre-fill on underrun, holds
// the DACs in reset while not playing and drives UART flow control with
// hysteresis.
// Optional feature macro: PLAYBACK_SEQ_UNDERRUN_COUNT_EN adds a saturating
// 16-bit underrun counter output (underrun_count).
module playback_sequencer #(
    parameter int FILL_BITS   = 12,
    parameter int START_LEVEL = 2048,
    parameter int LO_MARK     = 1024,
    parameter int HI_MARK     = 3072
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 play_en,
    input  logic                 sample_tick,
    input  logic [FILL_BITS-1:0] fifo_fill,
    input  logic                 fifo_empty,
    input  logic                 fifo_full,
    output logic                 fifo_rd_en,
    output logic                 dac_reset,
    output logic                 tx_allow,
    output logic                 playing,
`ifdef PLAYBACK_SEQ_UNDERRUN_COUNT_EN
    output logic [15:0]          underrun_count,
`endif
    output logic                 underrun
);

    // Thresholds truncated to the width of the fill input; all compares are unsigned.
    localparam logic [FILL_BITS-1:0] START_T = FILL_BITS'(START_LEVEL);
    localparam logic [FILL_BITS-1:0] LO_T    = FILL_BITS'(LO_MARK);
    localparam logic [FILL_BITS-1:0] HI_T    = FILL_BITS'(HI_MARK);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFILL,
        S_PLAY
    } state_e;

    state_e state_q;
    logic   rd_en_q;
    logic   dac_reset_q;
    logic   tx_allow_q;
    logic   playing_q;
    logic   underrun_q;

    // Playback FSM with registered outputs; play_en=0 overrides every other transition.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            rd_en_q     <= 1'b0;
            dac_reset_q <= 1'b1;
            playing_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            // Strobes default low so they are single-cycle pulses.
            rd_en_q    <= 1'b0;
            underrun_q <= 1'b0;
            if (!play_en) begin
                state_q     <= S_IDLE;
                dac_reset_q <= 1'b1;
                playing_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        state_q <= S_PREFILL;
                    end
                    S_PREFILL: begin
                        // Ticks are ignored here, so a tick on the entry cycle never reads.
                        if (fifo_fill >= START_T || fifo_full) begin
                            state_q     <= S_PLAY;
                            dac_reset_q <= 1'b0;
                            playing_q   <= 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (sample_tick) begin
                            if (fifo_empty) begin
                                underrun_q  <= 1'b1;
                                state_q     <= S_PREFILL;
                                dac_reset_q <= 1'b1;
                                playing_q   <= 1'b0;
                            end else if (!rd_en_q) begin
                                // Back-to-back ticks never produce back-to-back reads.
                                rd_en_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        dac_reset_q <= 1'b1;
                        playing_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Flow control with hysteresis; a full FIFO closes it even when the fill count wraps to 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_allow_q <= 1'b1;
        end else if (fifo_full || fifo_fill >= HI_T) begin
            tx_allow_q <= 1'b0;
        end else if (fifo_fill <= LO_T) begin
            tx_allow_q <= 1'b1;
        end
    end

`ifdef PLAYBACK_SEQ_UNDERRUN_COUNT_EN
    logic [15:0] underrun_count_q;
    logic [15:0] underrun_count_d;

    // Next count: cleared when a new session leaves IDLE, saturating increment on underrun.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        underrun_count_d = underrun_count_q;
        if (play_en && state_q == S_IDLE) begin
            underrun_count_d = 16'd0;
        end else if (play_en && state_q == S_PLAY && sample_tick && fifo_empty
                     && underrun_count_q != 16'hFFFF) begin
            underrun_count_d = underrun_count_q + 16'd1;
        end
    end

    // Underrun counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            underrun_count_q <= 16'd0;
        end else begin
            underrun_count_q <= underrun_count_d;
        end
    end

    assign underrun_count = underrun_count_q;
`endif

    assign fifo_rd_en = rd_en_q;
    assign dac_reset  = dac_reset_q;
    assign tx_allow   = tx_allow_q;
    assign playing    = playing_q;
    assign underrun   = underrun_q;

endmodule
